// File: rtl/lif_step_scheduler.sv
// Time-multiplexes one external LIF update datapath across NUM_NEURONS neuron contexts.
// Optional: define LIF_SCHED_OVERRUN_EN to flag step_start requests that arrive while busy.
module lif_step_scheduler #(
  parameter int NUM_NEURONS    = 8,
  parameter int IDX_W          = 3,
  parameter int MEMBRANE_WIDTH = 12,
  parameter int INPUT_WIDTH    = 8,
  parameter int REFR_WIDTH     = 4,
  parameter int EVT_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_start,
  output logic [IDX_W-1:0]          in_idx,
  input  logic [INPUT_WIDTH-1:0]    in_current,
  output logic                      dp_valid,
  output logic [IDX_W-1:0]          dp_idx,
  output logic [MEMBRANE_WIDTH-1:0] dp_membrane,
  output logic [REFR_WIDTH-1:0]     dp_refractory,
  output logic [INPUT_WIDTH-1:0]    dp_current,
  input  logic [MEMBRANE_WIDTH-1:0] dp_next_membrane,
  input  logic [REFR_WIDTH-1:0]     dp_next_refractory,
  input  logic                      dp_spike,
  output logic                      evt_valid,
  output logic [IDX_W-1:0]          evt_idx,
  input  logic                      evt_ready,
  output logic                      busy,
  output logic                      step_done,
  output logic [15:0]               step_count,
  output logic                      overrun
);

  localparam int EPTR_W = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CNT_W  = EPTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(EVT_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_COMMIT, S_DONE} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          in_idx_q;
  logic [INPUT_WIDTH-1:0]    cur_q;
  logic [MEMBRANE_WIDTH-1:0] lat_mem;
  logic [REFR_WIDTH-1:0]     lat_refr;
  logic                      lat_spike;

  logic [MEMBRANE_WIDTH-1:0] ctx_mem  [NUM_NEURONS];
  logic [REFR_WIDTH-1:0]     ctx_refr [NUM_NEURONS];

  logic [IDX_W-1:0]  evt_mem [EVT_DEPTH];
  logic [EPTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  evt_count;

  logic stall, commit_ok, push, pop;

  // Full check ignores a same-cycle pop so the stall never depends on evt_ready.
  assign stall     = lat_spike && (evt_count == FULL_CNT);
  assign commit_ok = (state == S_COMMIT) && !stall;
  assign push      = commit_ok && lat_spike;
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = (state != S_IDLE);
    step_done     = (state == S_DONE);
    dp_valid      = (state == S_EXEC);
    in_idx        = in_idx_q;
    dp_idx        = idx;
    dp_membrane   = ctx_mem[idx];
    dp_refractory = ctx_refr[idx];
    dp_current    = cur_q;
    evt_valid     = (evt_count != '0);
    evt_idx       = evt_mem[rd_ptr];
    case (state)
      S_IDLE:   if (step_start) state_next = S_FETCH;
      S_FETCH: begin
        in_idx     = idx;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        dp_current = in_current;
        state_next = S_COMMIT;
      end
      S_COMMIT: if (!stall) state_next = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      in_idx_q   <= '0;
      cur_q      <= '0;
      lat_mem    <= '0;
      lat_refr   <= '0;
      lat_spike  <= 1'b0;
      step_count <= '0;
    end else begin
      if (state == S_IDLE && step_start) idx <= '0;
      if (commit_ok && idx != LAST_IDX)  idx <= idx + 1'b1;
      if (state == S_FETCH) in_idx_q <= idx;
      if (state == S_EXEC) begin
        cur_q     <= in_current;
        lat_mem   <= dp_next_membrane;
        lat_refr  <= dp_next_refractory;
        lat_spike <= dp_spike;
      end
      if (state == S_DONE) step_count <= step_count + 16'd1;
    end
  end

  // NOTE: contexts and queue storage are reset explicitly because reset must
  // leave every neuron and event slot at zero; that rules out a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ctx_mem[i]  <= '0;
        ctx_refr[i] <= '0;
      end
    end else if (commit_ok) begin
      ctx_mem[idx]  <= lat_mem;
      ctx_refr[idx] <= lat_refr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < EVT_DEPTH; i++) evt_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      if (push) begin
        evt_mem[wr_ptr] <= idx;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

`ifdef LIF_SCHED_OVERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  overrun <= 1'b0;
    else if (step_start && busy) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule
